// File: rtl/fs_sweep_pkg.sv
// Shared definitions for the fast-square sweep sequencer: state encoding,
// config register field positions and fixed timing constants.
package fs_sweep_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RESTART = 3'd1,
      ST_SETTLE  = 3'd2,
      ST_RECORD  = 3'd3,
      ST_STEP    = 3'd4,
      ST_DONE    = 3'd5
   } sweep_state_t;

   // Config register layout
   localparam int CFG_ENABLE_BIT = 31;
   localparam int CFG_CONT_BIT   = 30;
   localparam int CFG_STEPS_MSB  = 23;
   localparam int CFG_STEPS_LSB  = 16;
   localparam int CFG_SETTLE_MSB = 15;
   localparam int CFG_SETTLE_LSB = 0;

   // Length of the datapath restart pulse in clock cycles
   localparam int RESTART_CYCLES = 2;

   // Timer must hold the 16-bit settle value and the record window load
   function automatic int timer_width(input int record_log2);
      return ((record_log2 + 1) > 17) ? (record_log2 + 1) : 17;
   endfunction

endpackage

// File: rtl/fs_sweep_timer.sv
// Loadable down-counter used for the restart, settle and record windows.
// Counts toward zero and holds there; zero flags the terminal count.
module fs_sweep_timer #(
   parameter int WIDTH = 17
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             en,
   input  logic [WIDTH-1:0] load_val,
   output logic             zero
);

   logic [WIDTH-1:0] count;

   // Load has priority; otherwise decrement while enabled and not yet at zero
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - WIDTH'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/setting_reg.sv
// Serial setting bus register: captures the data word when the strobe hits
// this register's address and pulses changed in the following cycle.
module setting_reg #(
   parameter int               ADDR     = 0,
   parameter int               AWIDTH   = 7,
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] AT_RESET = '0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              strobe,
   input  logic [AWIDTH-1:0] addr,
   input  logic [WIDTH-1:0]  data,
   output logic [WIDTH-1:0]  value,
   output logic              changed
);

   // Capture on an address match; changed flags every write, even same value
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         value   <= AT_RESET;
         changed <= 1'b0;
      end else if (strobe && (addr == AWIDTH'(ADDR))) begin
         value   <= data;
         changed <= 1'b1;
      end else begin
         changed <= 1'b0;
      end
   end

endmodule

// File: rtl/fast_square_sweep_ctrl.sv
// Stepped-frequency sweep sequencer for the fast-square subcarrier receive
// datapath. Restarts the datapath, then per step settles, records for a
// fixed power-of-two window and pulses freq_step. Tracks readout of the
// latched subcarrier words and flags overrun if a step lands on undrained data.
module fast_square_sweep_ctrl
   import fs_sweep_pkg::*;
#(
   parameter int CFG_ADDR          = 0,
   parameter int RECORD_TICKS_LOG2 = 14,
   parameter int NUM_SUBCARRIERS   = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [6:0]  serial_addr,
   input  logic [31:0] serial_data,
   input  logic        serial_strobe,
   input  logic        data_out_strobe,
   output logic        rx_reset,
   output logic        freq_step,
   output logic        record,
   output logic        busy,
   output logic [7:0]  step_idx,
   output logic        sweep_done,
   output logic        overrun
);

   localparam int            TW         = timer_width(RECORD_TICKS_LOG2);
   localparam logic [TW-1:0] REC_LOAD   = TW'((64'd1 << RECORD_TICKS_LOG2) - 64'd1);
   localparam logic [TW-1:0] RST_LOAD   = TW'(RESTART_CYCLES - 1);
   localparam int            DW         = $clog2(NUM_SUBCARRIERS + 1);
   localparam logic [DW-1:0] DRAIN_FULL = DW'(NUM_SUBCARRIERS);

   sweep_state_t  state;
   logic [31:0]   cfg;
   logic          cfg_changed;
   logic          enable_live;
   logic          cont_l;
   logic [7:0]    steps_l;
   logic [15:0]   settle_l;
   logic          last_step;
   logic          abort;
   logic          tmr_load;
   logic [TW-1:0] tmr_val;
   logic          tmr_zero;
   logic [DW-1:0] drain_cnt;
   logic [DW-1:0] drain_inc;
   logic          overrun_set;
   logic          unused_cfg_bits;

   setting_reg #(
      .ADDR     (CFG_ADDR),
      .AWIDTH   (7),
      .WIDTH    (32),
      .AT_RESET (32'd0)
   ) u_cfg (
      .clock   (clock),
      .reset   (reset),
      .strobe  (serial_strobe),
      .addr    (serial_addr),
      .data    (serial_data),
      .value   (cfg),
      .changed (cfg_changed)
   );

   assign enable_live     = cfg[CFG_ENABLE_BIT];
   assign unused_cfg_bits = ^cfg[29:24];
   // 8-bit wrap makes a latched count of 0 mean 256 steps
   assign last_step       = (step_idx == (steps_l - 8'd1));
   assign abort           = !enable_live &&
                            (state inside {ST_RESTART, ST_SETTLE, ST_RECORD, ST_STEP});

   // Timer reload at each window boundary, in step with the FSM transitions
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = '0;
      unique case (state)
         ST_IDLE: if (enable_live) begin
            tmr_load = 1'b1;
            tmr_val  = RST_LOAD;
         end
         ST_RESTART: if (enable_live && tmr_zero) begin
            tmr_load = 1'b1;
            tmr_val  = TW'(settle_l);
         end
         ST_SETTLE: if (enable_live && tmr_zero) begin
            tmr_load = 1'b1;
            tmr_val  = REC_LOAD;
         end
         ST_STEP: if (enable_live && !last_step) begin
            tmr_load = 1'b1;
            tmr_val  = TW'(settle_l);
         end
         ST_DONE: if (enable_live && cont_l) begin
            tmr_load = 1'b1;
            tmr_val  = RST_LOAD;
         end
         default: ;
      endcase
   end

   fs_sweep_timer #(.WIDTH(TW)) u_timer (
      .clock    (clock),
      .reset    (reset),
      .load     (tmr_load),
      .en       (busy),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   // Sweep sequencer; outputs are registered alongside the state they describe
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         rx_reset   <= 1'b0;
         freq_step  <= 1'b0;
         record     <= 1'b0;
         busy       <= 1'b0;
         step_idx   <= 8'd0;
         sweep_done <= 1'b0;
         cont_l     <= 1'b0;
         steps_l    <= 8'd0;
         settle_l   <= 16'd0;
      end else begin
         freq_step  <= 1'b0;
         sweep_done <= 1'b0;
         if (abort) begin
            // Enable dropped mid-sweep: stop quietly, keep step_idx
            state    <= ST_IDLE;
            rx_reset <= 1'b0;
            record   <= 1'b0;
            busy     <= 1'b0;
         end else begin
            unique case (state)
               ST_IDLE: if (enable_live) begin
                  cont_l   <= cfg[CFG_CONT_BIT];
                  steps_l  <= cfg[CFG_STEPS_MSB:CFG_STEPS_LSB];
                  settle_l <= cfg[CFG_SETTLE_MSB:CFG_SETTLE_LSB];
                  state    <= ST_RESTART;
                  rx_reset <= 1'b1;
                  busy     <= 1'b1;
                  step_idx <= 8'd0;
               end
               ST_RESTART: if (tmr_zero) begin
                  state    <= ST_SETTLE;
                  rx_reset <= 1'b0;
               end
               ST_SETTLE: if (tmr_zero) begin
                  state  <= ST_RECORD;
                  record <= 1'b1;
               end
               ST_RECORD: if (tmr_zero) begin
                  state     <= ST_STEP;
                  record    <= 1'b0;
                  freq_step <= 1'b1;
               end
               ST_STEP: begin
                  if (last_step) begin
                     state      <= ST_DONE;
                     sweep_done <= 1'b1;
                  end else begin
                     state    <= ST_SETTLE;
                     step_idx <= step_idx + 8'd1;
                  end
               end
               ST_DONE: begin
                  if (enable_live && cont_l) begin
                     state    <= ST_RESTART;
                     rx_reset <= 1'b1;
                     step_idx <= 8'd0;
                  end else begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   // A read in the STEP cycle still belongs to the window being closed
   always_comb begin
      drain_inc = drain_cnt;
      if (data_out_strobe && (drain_cnt < DRAIN_FULL)) begin
         drain_inc = drain_cnt + DW'(1);
      end
   end

   assign overrun_set = (state == ST_STEP) && (drain_inc < DRAIN_FULL);

   // Readout tracking and sticky overrun; a new overrun outranks a config clear
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         drain_cnt <= DRAIN_FULL;
         overrun   <= 1'b0;
      end else begin
         if (overrun_set) begin
            overrun <= 1'b1;
         end else if (cfg_changed) begin
            overrun <= 1'b0;
         end
         if (state == ST_STEP) begin
            drain_cnt <= '0;
         end else if (state == ST_RESTART) begin
            drain_cnt <= DRAIN_FULL;
         end else begin
            drain_cnt <= drain_inc;
         end
      end
   end

endmodule

// File: tb/tb_fast_square_sweep_ctrl.sv
// Bench for fast_square_sweep_ctrl with a short record window. A timing
// model predicts every restart, record start, step and done event as an
// absolute cycle number; a monitor pops and compares them as they appear.
module tb_fast_square_sweep_ctrl;

   localparam int REC_LOG2 = 4;
   localparam int REC_LEN  = 16;
   localparam int NSUB     = 4;
   localparam int EV_RST   = 0;
   localparam int EV_REC   = 1;
   localparam int EV_STEP  = 2;
   localparam int EV_DONE  = 3;

   typedef struct {
      int cyc;
      int kind;
      int val;
   } ev_t;

   ev_t exp_q[$];

   logic        clock = 1'b0;
   logic        reset;
   logic [6:0]  serial_addr;
   logic [31:0] serial_data;
   logic        serial_strobe;
   logic        data_out_strobe;
   logic        rx_reset;
   logic        freq_step;
   logic        record;
   logic        busy;
   logic [7:0]  step_idx;
   logic        sweep_done;
   logic        overrun;

   int edge_cnt    = 0;
   int vectors     = 0;
   int miscompares = 0;

   fast_square_sweep_ctrl #(
      .CFG_ADDR          (0),
      .RECORD_TICKS_LOG2 (REC_LOG2),
      .NUM_SUBCARRIERS   (NSUB)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .serial_addr     (serial_addr),
      .serial_data     (serial_data),
      .serial_strobe   (serial_strobe),
      .data_out_strobe (data_out_strobe),
      .rx_reset        (rx_reset),
      .freq_step       (freq_step),
      .record          (record),
      .busy            (busy),
      .step_idx        (step_idx),
      .sweep_done      (sweep_done),
      .overrun         (overrun)
   );

   // Clock and absolute cycle counter
   always #5 clock = ~clock;
   always @(posedge clock) edge_cnt <= edge_cnt + 1;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, edge_cnt);
      end
   endtask

   // Model: absolute cycle of every event of a sweep started by a write at edge w
   task automatic push_sweep(input int w, input int s, input int n, input int rounds);
      int c0;
      int rec0;
      int period;
      ev_t e;
      period = s + 1 + REC_LEN + 1;
      c0 = w + 1;
      for (int r = 0; r < rounds; r++) begin
         e.cyc = c0; e.kind = EV_RST; e.val = 0; exp_q.push_back(e);
         rec0 = c0 + 2 + s + 1;
         for (int k = 0; k < n; k++) begin
            e.cyc = rec0 + k * period; e.kind = EV_REC; e.val = 0; exp_q.push_back(e);
            e.cyc = rec0 + k * period + REC_LEN; e.kind = EV_STEP; e.val = k; exp_q.push_back(e);
         end
         e.cyc = rec0 + (n - 1) * period + REC_LEN + 1; e.kind = EV_DONE; e.val = 0;
         exp_q.push_back(e);
         c0 = e.cyc + 1;
      end
   endtask

   task automatic expect_event(input int kind, input int val);
      ev_t e;
      if (exp_q.size() == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", kind, edge_cnt);
      end else begin
         e = exp_q.pop_front();
         check($sformatf("event_kind@%0d", e.cyc), kind, e.kind);
         check($sformatf("event%0d_cycle", kind), edge_cnt, e.cyc);
         if (kind == EV_STEP) check("step_idx_at_step", val, e.val);
      end
   endtask

   // Monitor: turns output activity into events and checks window lengths
   logic prev_rx  = 1'b0;
   logic prev_rec = 1'b0;
   int   rx_run   = 0;
   int   rec_run  = 0;
   always @(negedge clock) begin
      if (reset) begin
         prev_rx  = 1'b0;
         prev_rec = 1'b0;
         rx_run   = 0;
         rec_run  = 0;
      end else begin
         if (rx_reset && !prev_rx) expect_event(EV_RST, 0);
         if (!rx_reset && prev_rx) check("rx_reset_len", rx_run, 2);
         if (record && !prev_rec) expect_event(EV_REC, 0);
         if (freq_step) begin
            expect_event(EV_STEP, int'(step_idx));
            check("record_len", rec_run, REC_LEN);
         end
         if (sweep_done) begin
            expect_event(EV_DONE, 0);
            check("busy_in_done", int'(busy), 1);
         end
         if (rx_reset) rx_run = prev_rx ? rx_run + 1 : 1;
         if (record) rec_run = prev_rec ? rec_run + 1 : 1;
         prev_rx  = rx_reset;
         prev_rec = record;
      end
   end

   // Driver: config write; call at a falling edge, returns one cycle later
   task automatic write_cfg(input bit en, input bit cont, input int steps, input int settle,
                            output int w);
      logic [7:0]  st8;
      logic [15:0] se16;
      st8  = steps[7:0];
      se16 = settle[15:0];
      serial_addr   = 7'd0;
      serial_data   = {en, cont, 6'd0, st8, se16};
      serial_strobe = 1'b1;
      w = edge_cnt + 1;
      @(negedge clock);
      serial_strobe = 1'b0;
   endtask

   task automatic strobes(input int k);
      repeat (k) begin
         data_out_strobe = 1'b1;
         @(negedge clock);
         data_out_strobe = 1'b0;
         @(negedge clock);
      end
   endtask

   // Bounded wait for an output: 0 freq_step, 1 sweep_done, 2 record
   task automatic wait_sig(input int which, input int lim, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < lim; i++) begin
         @(negedge clock);
         if ((which == 0 && freq_step) || (which == 1 && sweep_done) ||
             (which == 2 && record)) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         vectors++;
         miscompares++;
         $display("FAIL wait_timeout: signal %0d not seen within %0d cycles, expected it", which, lim);
      end
   endtask

   task automatic end_checks(input string tag);
      check({tag, "_busy_idle"}, int'(busy), 0);
      check({tag, "_queue_empty"}, exp_q.size(), 0);
      exp_q.delete();
   endtask

   // Single sweep; mode 0: 4 reads per step, 1: random 2..5, 2: only 3 before step 1
   task automatic run_single(input int s, input int n_raw, input int mode);
      int w;
      int n;
      int k_str;
      bit ok;
      bit exp_ovr;
      n = (n_raw == 0) ? 256 : n_raw;
      write_cfg(1'b1, 1'b0, n_raw, s, w);
      push_sweep(w, s, n, 1);
      exp_ovr = 1'b0;
      ok = 1'b1;
      for (int k = 0; k < n && ok; k++) begin
         wait_sig(0, 200, ok);
         if (ok && k < n - 1) begin
            case (mode)
               0:       k_str = NSUB;
               1:       k_str = $urandom_range(2, 5);
               default: k_str = (k == 0) ? NSUB - 1 : NSUB;
            endcase
            if (k_str < NSUB) exp_ovr = 1'b1;
            @(negedge clock);
            strobes(k_str);
         end
      end
      wait_sig(1, 10, ok);
      check("overrun_at_done", int'(overrun), int'(exp_ovr));
      check("step_idx_at_done", int'(step_idx), (n - 1) % 256);
      write_cfg(1'b0, 1'b0, 0, 0, w);
      repeat (3) @(negedge clock);
      check("overrun_after_cfg", int'(overrun), 0);
      end_checks("single");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int  w;
      bit  ok;
      ev_t e;
      reset           = 1'b1;
      serial_addr     = 7'd0;
      serial_data     = 32'd0;
      serial_strobe   = 1'b0;
      data_out_strobe = 1'b0;
      repeat (3) @(negedge clock);
      check("rst_rx_reset", int'(rx_reset), 0);
      check("rst_freq_step", int'(freq_step), 0);
      check("rst_record", int'(record), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_step_idx", int'(step_idx), 0);
      check("rst_sweep_done", int'(sweep_done), 0);
      check("rst_overrun", int'(overrun), 0);
      reset = 1'b0;
      repeat (2) @(negedge clock);

      // Reference sweep, fully drained, then short drain before the second step
      run_single(3, 2, 0);
      run_single(3, 2, 2);

      // Continuous single-step sweeps, stopped by dropping enable in the last STEP
      write_cfg(1'b1, 1'b1, 1, 3, w);
      push_sweep(w, 3, 1, 3);
      for (int r = 0; r < 3; r++) wait_sig(0, 100, ok);
      write_cfg(1'b0, 1'b0, 0, 0, w);
      repeat (4) @(negedge clock);
      end_checks("cont");

      // Full 256-step sweep with zero settle
      run_single(0, 0, 0);

      // Randomized sweeps with random readout counts
      for (int i = 0; i < 6; i++) run_single($urandom_range(0, 6), $urandom_range(1, 4), 1);

      // Abort in the middle of a record window
      write_cfg(1'b1, 1'b0, 3, 2, w);
      e.cyc = w + 1; e.kind = EV_RST; e.val = 0; exp_q.push_back(e);
      e.cyc = w + 1 + 2 + 3; e.kind = EV_REC; e.val = 0; exp_q.push_back(e);
      wait_sig(2, 50, ok);
      repeat (5) @(negedge clock);
      write_cfg(1'b0, 1'b0, 0, 0, w);
      @(negedge clock);
      check("abort_record", int'(record), 0);
      check("abort_busy", int'(busy), 0);
      check("abort_step_idx", int'(step_idx), 0);
      repeat (40) @(negedge clock);
      end_checks("abort");

      // Asynchronous reset during the second settle window
      write_cfg(1'b1, 1'b0, 3, 3, w);
      e.cyc = w + 1; e.kind = EV_RST; e.val = 0; exp_q.push_back(e);
      e.cyc = w + 1 + 2 + 4; e.kind = EV_REC; e.val = 0; exp_q.push_back(e);
      e.cyc = w + 1 + 2 + 4 + REC_LEN; e.kind = EV_STEP; e.val = 0; exp_q.push_back(e);
      wait_sig(0, 100, ok);
      repeat (2) @(negedge clock);
      check("pre_reset_step_idx", int'(step_idx), 1);
      #2 reset = 1'b1;
      #1;
      check("areset_busy", int'(busy), 0);
      check("areset_rx_reset", int'(rx_reset), 0);
      check("areset_record", int'(record), 0);
      check("areset_step_idx", int'(step_idx), 0);
      check("areset_freq_step", int'(freq_step), 0);
      check("areset_sweep_done", int'(sweep_done), 0);
      check("areset_overrun", int'(overrun), 0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      end_checks("areset");
      run_single(1, 2, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
